// File: rtl/adaptive_light_sequencer_if.sv
// Sequencer I/O bundle: timebase strobe and vehicle sensors in, lamp drive and
// phase status out.
//   tick       - one-cycle timebase strobe
//   car_ns/ew  - level vehicle sensors, synchronous to clk
//   ns/ew_light- lamps {R,Y,G}, one-hot
//   phase      - state code 0..5
//   remaining  - ticks left in the current phase
//   phase_done - one-cycle pulse on every state change
interface adaptive_light_sequencer_if #(
   parameter int unsigned TW = 8
) ();
   logic          tick;
   logic          car_ns;
   logic          car_ew;
   logic [2:0]    ns_light;
   logic [2:0]    ew_light;
   logic [2:0]    phase;
   logic [TW-1:0] remaining;
   logic          phase_done;

   // Driver side: timebase/sensors, observes lamps and status
   modport master (
      output tick, car_ns, car_ew,
      input  ns_light, ew_light, phase, remaining, phase_done
   );

   // Sequencer side
   modport slave (
      input  tick, car_ns, car_ew,
      output ns_light, ew_light, phase, remaining, phase_done
   );
endinterface

// File: rtl/adaptive_light_sequencer.sv
// Two-road (NS/EW) traffic phase sequencer. Counts phase durations in ticks,
// extends green while the active road keeps demanding, rests in green when the
// cross road has no demand, and latches cross-road demand so that single-cycle
// sensor pulses are never lost.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of adaptive_light_sequencer_if (see interface header)
module adaptive_light_sequencer #(
   parameter int unsigned GREEN_MIN = 8,
   parameter int unsigned GREEN_MAX = 20,
   parameter int unsigned EXTEND    = 4,
   parameter int unsigned YELLOW    = 3,
   parameter int unsigned ALL_RED   = 1,
   parameter int unsigned TW        = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   adaptive_light_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_A = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_B = 3'd5
   } state_e;

   localparam logic [TW-1:0] ONE_T    = TW'(1);
   localparam logic [TW-1:0] GMIN_T   = TW'(GREEN_MIN);
   localparam logic [TW-1:0] GMAX_T   = TW'(GREEN_MAX);
   localparam logic [TW:0]   GMAX_W   = (TW+1)'(GREEN_MAX);
   localparam logic [TW-1:0] EXT_T    = TW'(EXTEND);
   localparam logic [TW-1:0] YEL_T    = TW'(YELLOW);
   localparam logic [TW-1:0] AR_T     = TW'(ALL_RED);
   localparam logic [2:0]    LAMP_G   = 3'b001;
   localparam logic [2:0]    LAMP_Y   = 3'b010;
   localparam logic [2:0]    LAMP_R   = 3'b100;

   state_e        state_q, state_d;
   logic [TW-1:0] rem_q, rem_d;
   logic [TW-1:0] el_q, el_d;
   logic          dem_ns_q, dem_ns_d;
   logic          dem_ew_q, dem_ew_d;
   logic [2:0]    ns_q, ns_d;
   logic [2:0]    ew_q, ew_d;
   logic          done_q, done_d;

   logic          is_ns_green;
   logic          is_green;
   logic          cur_car;
   logic          opp_req;
   logic [TW:0]   e1;
   logic [TW-1:0] el_sat;
   logic [TW-1:0] room;

   // Green-phase decision inputs
   assign is_ns_green = (state_q == NS_GREEN);
   assign is_green    = is_ns_green || (state_q == EW_GREEN);
   assign cur_car     = is_ns_green ? bus.car_ns : bus.car_ew;
   assign opp_req     = is_ns_green ? (dem_ew_q | bus.car_ew) : (dem_ns_q | bus.car_ns);

   // e1 carries an extra bit so the compare against GREEN_MAX cannot wrap;
   // room is only consumed when e1 < GREEN_MAX, so e1 fits in TW bits there.
   assign e1     = {1'b0, el_q} + (TW+1)'(1);
   assign el_sat = (e1 >= GMAX_W) ? GMAX_T : e1[TW-1:0];
   assign room   = GMAX_T - e1[TW-1:0];

   // Next-state, timer and demand-latch logic
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      el_d     = el_q;
      done_d   = 1'b0;
      dem_ns_d = dem_ns_q | (bus.car_ns & (state_q != NS_GREEN));
      dem_ew_d = dem_ew_q | (bus.car_ew & (state_q != EW_GREEN));

      if (bus.tick) begin
         if (rem_q > ONE_T) begin
            rem_d = rem_q - ONE_T;
            if (is_green) begin
               el_d = el_sat;
            end
         end else begin
            unique case (state_q)
               NS_GREEN, EW_GREEN: begin
                  if (cur_car && (e1 < GMAX_W)) begin
                     // Extension, clipped so green never exceeds GREEN_MAX
                     rem_d = (room < EXT_T) ? room : EXT_T;
                     el_d  = e1[TW-1:0];
                  end else if (opp_req) begin
                     state_d = is_ns_green ? NS_YELLOW : EW_YELLOW;
                     rem_d   = YEL_T;
                     done_d  = 1'b1;
                  end else begin
                     // Rest in green; re-evaluated on every later tick
                     rem_d = ONE_T;
                     el_d  = el_sat;
                  end
               end
               NS_YELLOW: begin
                  state_d = ALL_RED_A;
                  rem_d   = AR_T;
                  done_d  = 1'b1;
               end
               ALL_RED_A: begin
                  state_d  = EW_GREEN;
                  rem_d    = GMIN_T;
                  el_d     = '0;
                  dem_ew_d = 1'b0;
                  done_d   = 1'b1;
               end
               EW_YELLOW: begin
                  state_d = ALL_RED_B;
                  rem_d   = AR_T;
                  done_d  = 1'b1;
               end
               ALL_RED_B: begin
                  state_d  = NS_GREEN;
                  rem_d    = GMIN_T;
                  el_d     = '0;
                  dem_ns_d = 1'b0;
                  done_d   = 1'b1;
               end
               default: begin
                  state_d  = NS_GREEN;
                  rem_d    = GMIN_T;
                  el_d     = '0;
                  dem_ns_d = 1'b0;
                  done_d   = 1'b1;
               end
            endcase
         end
      end
   end

   // Lamp decode of the next state, registered alongside it
   always_comb begin
      ns_d = LAMP_R;
      ew_d = LAMP_R;
      unique case (state_d)
         NS_GREEN:  ns_d = LAMP_G;
         NS_YELLOW: ns_d = LAMP_Y;
         EW_GREEN:  ew_d = LAMP_G;
         EW_YELLOW: ew_d = LAMP_Y;
         default: begin
            ns_d = LAMP_R;
            ew_d = LAMP_R;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= NS_GREEN;
         rem_q    <= GMIN_T;
         el_q     <= '0;
         dem_ns_q <= 1'b0;
         dem_ew_q <= 1'b0;
         ns_q     <= LAMP_G;
         ew_q     <= LAMP_R;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         el_q     <= el_d;
         dem_ns_q <= dem_ns_d;
         dem_ew_q <= dem_ew_d;
         ns_q     <= ns_d;
         ew_q     <= ew_d;
         done_q   <= done_d;
      end
   end

   assign bus.phase      = state_q;
   assign bus.remaining  = rem_q;
   assign bus.ns_light   = ns_q;
   assign bus.ew_light   = ew_q;
   assign bus.phase_done = done_q;

endmodule

// File: tb/tb_adaptive_light_sequencer.sv
// Bench for adaptive_light_sequencer: two instances (GREEN_MAX 20 and 10) share
// one stimulus stream. A behavioural model predicts every cycle into per-DUT
// scoreboard queues; a vector table adds hand-derived phase/remaining
// checkpoints, and a short hand sequence covers single-pulse demand capture.
module tb_adaptive_light_sequencer;
   localparam int unsigned TW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adaptive_light_sequencer_if #(.TW(TW)) if0 ();
   adaptive_light_sequencer_if #(.TW(TW)) if1 ();

   adaptive_light_sequencer #(.TW(TW)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   adaptive_light_sequencer #(.GREEN_MAX(10), .TW(TW)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   typedef struct {
      int st;
      int rem;
      int el;
      bit dns;
      bit dew;
   } mst_t;

   typedef struct {
      int         ph;
      int         rem;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       pd;
   } exp_t;

   typedef struct {
      int n;
      int per;
      bit cn;
      bit ce;
      bit rn;
      int ph0;
      int r0;
      int ph1;
      int r1;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   mst_t m0;
   mst_t m1;
   vec_t tbl[27];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic int dur(input int st);
      case (st)
         0, 3:    return 8;
         1, 4:    return 3;
         default: return 1;
      endcase
   endfunction

   function automatic logic [2:0] ns_lamp(input int st);
      if (st == 0) return 3'b001;
      if (st == 1) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic [2:0] ew_lamp(input int st);
      if (st == 3) return 3'b001;
      if (st == 4) return 3'b010;
      return 3'b100;
   endfunction

   // One clock of the reference behaviour; pd reports a state change
   function automatic mst_t mstep(input mst_t s, input bit rn, input bit t,
                                  input bit cn, input bit ce, input int gmax,
                                  output bit pd);
      mst_t n;
      bit   green;
      bit   mine;
      bit   other;
      int   e1;
      n  = s;
      pd = 1'b0;
      if (!rn) begin
         n.st = 0; n.rem = 8; n.el = 0; n.dns = 1'b0; n.dew = 1'b0;
         return n;
      end
      if (cn && s.st != 0) n.dns = 1'b1;
      if (ce && s.st != 3) n.dew = 1'b1;
      green = (s.st == 0) || (s.st == 3);
      mine  = (s.st == 0) ? cn : ce;
      other = (s.st == 0) ? (s.dew | ce) : (s.dns | cn);
      e1    = s.el + 1;
      if (t) begin
         if (s.rem > 1) begin
            n.rem = s.rem - 1;
            if (green) n.el = (e1 > gmax) ? gmax : e1;
         end else if (green) begin
            if (mine && e1 < gmax) begin
               n.rem = (gmax - e1 < 4) ? gmax - e1 : 4;
               n.el  = e1;
            end else if (other) begin
               n.st  = s.st + 1;
               n.rem = 3;
               pd    = 1'b1;
            end else begin
               n.rem = 1;
               n.el  = (e1 > gmax) ? gmax : e1;
            end
         end else begin
            n.st  = (s.st + 1) % 6;
            n.rem = dur(n.st);
            pd    = 1'b1;
            if (n.st == 0) begin n.el = 0; n.dns = 1'b0; end
            if (n.st == 3) begin n.el = 0; n.dew = 1'b0; end
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic sb_check(input string tag, input exp_t e, input logic [2:0] ph,
                           input logic [TW-1:0] rem, input logic [2:0] ns,
                           input logic [2:0] ew, input logic pd);
      chk({tag, ".phase"}, 32'(ph), 32'(e.ph));
      chk({tag, ".remaining"}, 32'(rem), 32'(e.rem));
      chk({tag, ".ns_light"}, 32'(ns), 32'(e.ns));
      chk({tag, ".ew_light"}, 32'(ew), 32'(e.ew));
      chk({tag, ".phase_done"}, 32'(pd), 32'(e.pd));
      chk({tag, ".lamps_onehot"}, 32'($onehot(ns) && $onehot(ew)), 32'(1));
   endtask

   function automatic exp_t to_exp(input mst_t s, input bit pd);
      exp_t e;
      e.ph  = s.st;
      e.rem = s.rem;
      e.ns  = ns_lamp(s.st);
      e.ew  = ew_lamp(s.st);
      e.pd  = pd;
      return e;
   endfunction

   // Drive one cycle, predict, then compare both DUTs after the edge
   task automatic run_cycle(input bit t, input bit cn, input bit ce, input bit rn);
      bit   pd;
      exp_t e;
      @(negedge clk);
      if0.tick = t; if0.car_ns = cn; if0.car_ew = ce;
      if1.tick = t; if1.car_ns = cn; if1.car_ew = ce;
      rst_n = rn;
      m0 = mstep(m0, rn, t, cn, ce, 20, pd);
      q0.push_back(to_exp(m0, pd));
      m1 = mstep(m1, rn, t, cn, ce, 10, pd);
      q1.push_back(to_exp(m1, pd));
      @(posedge clk);
      #1;
      if (q0.size() == 0 || q1.size() == 0) begin
         chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'(2));
      end else begin
         e = q0.pop_front();
         sb_check("d0", e, if0.phase, if0.remaining, if0.ns_light, if0.ew_light, if0.phase_done);
         e = q1.pop_front();
         sb_check("d1", e, if1.phase, if1.remaining, if1.ns_light, if1.ew_light, if1.phase_done);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      if0.tick = 1'b0; if0.car_ns = 1'b0; if0.car_ew = 1'b0;
      if1.tick = 1'b0; if1.car_ns = 1'b0; if1.car_ew = 1'b0;
      m0 = '{0, 8, 0, 1'b0, 1'b0};
      m1 = '{0, 8, 0, 1'b0, 1'b0};

      //           n  per cn ce rn  ph0 r0 ph1 r1
      tbl[0]  = '{ 2, 1, 0, 0, 0,  0, 8, 0, 8};  // reset
      tbl[1]  = '{ 7, 1, 0, 0, 1,  0, 1, 0, 1};  // idle: remaining reaches 1
      tbl[2]  = '{ 5, 1, 0, 0, 1,  0, 1, 0, 1};  // rest in green
      tbl[3]  = '{ 1, 1, 0, 0, 0,  0, 8, 0, 8};  // reset
      tbl[4]  = '{ 2, 1, 0, 0, 1,  0, 6, 0, 6};
      tbl[5]  = '{ 1, 1, 0, 1, 1,  0, 5, 0, 5};  // EW pulse at tick 3
      tbl[6]  = '{ 4, 1, 0, 0, 1,  0, 1, 0, 1};
      tbl[7]  = '{ 1, 1, 0, 0, 1,  1, 3, 1, 3};  // yield after tick 8
      tbl[8]  = '{ 2, 1, 0, 0, 1,  1, 1, 1, 1};
      tbl[9]  = '{ 1, 1, 0, 0, 1,  2, 1, 2, 1};
      tbl[10] = '{ 1, 1, 0, 0, 1,  3, 8, 3, 8};  // EW green entry
      tbl[11] = '{ 7, 1, 0, 0, 1,  3, 1, 3, 1};
      tbl[12] = '{ 3, 1, 0, 0, 1,  3, 1, 3, 1};  // EW rests, no NS demand
      tbl[13] = '{ 1, 1, 0, 0, 0,  0, 8, 0, 8};  // reset
      tbl[14] = '{ 7, 1, 1, 1, 1,  0, 1, 0, 1};
      tbl[15] = '{ 1, 1, 1, 1, 1,  0, 4, 0, 2};  // ext at 8 (clipped on d1)
      tbl[16] = '{ 4, 1, 1, 1, 1,  0, 4, 1, 1};  // ext at 12; d1 yellow at 10
      tbl[17] = '{ 4, 1, 1, 1, 1,  0, 4, 3, 6};  // ext at 16
      tbl[18] = '{ 3, 1, 1, 1, 1,  0, 1, 3, 3};
      tbl[19] = '{ 1, 1, 1, 1, 1,  1, 3, 3, 2};  // yellow after tick 20
      tbl[20] = '{ 3, 1, 1, 1, 1,  2, 1, 3, 1};
      tbl[21] = '{ 1, 1, 1, 1, 1,  3, 8, 4, 3};
      tbl[22] = '{ 8, 1, 1, 0, 1,  4, 3, 0, 4};
      tbl[23] = '{ 1, 1, 1, 0, 1,  4, 2, 0, 3};  // d0 mid EW_YELLOW
      tbl[24] = '{ 1, 1, 1, 0, 0,  0, 8, 0, 8};  // reset on a tick cycle
      tbl[25] = '{70, 5, 0, 1, 1,  3, 6, 3, 6};  // sparse ticks, 14 ticks
      tbl[26] = '{ 4, 0, 0, 1, 1,  3, 6, 3, 6};  // no ticks: frozen

      foreach (tbl[k]) begin
         for (int i = 0; i < tbl[k].n; i++) begin
            bit t;
            if (tbl[k].per == 0)      t = 1'b0;
            else if (tbl[k].per == 1) t = 1'b1;
            else                      t = ((i % tbl[k].per) == tbl[k].per - 1);
            run_cycle(t, tbl[k].cn, tbl[k].ce, tbl[k].rn);
         end
         chk($sformatf("row%0d.d0.phase", k), 32'(if0.phase), 32'(tbl[k].ph0));
         chk($sformatf("row%0d.d0.remaining", k), 32'(if0.remaining), 32'(tbl[k].r0));
         chk($sformatf("row%0d.d1.phase", k), 32'(if1.phase), 32'(tbl[k].ph1));
         chk($sformatf("row%0d.d1.remaining", k), 32'(if1.remaining), 32'(tbl[k].r1));
      end

      // Single-cycle NS pulse on a non-tick cycle during EW rest is latched
      for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("rest.d0.phase", 32'(if0.phase), 32'(3));
      chk("rest.d0.remaining", 32'(if0.remaining), 32'(1));
      run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
      chk("pulse.d0.phase", 32'(if0.phase), 32'(3));
      run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("latched.d0.phase", 32'(if0.phase), 32'(4));
      chk("latched.d0.remaining", 32'(if0.remaining), 32'(3));
      chk("latched.d0.phase_done", 32'(if0.phase_done), 32'(1));
      chk("latched.d1.phase", 32'(if1.phase), 32'(4));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
